// File: rtl/mem_req_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_req_buffer : FIFO for memory requests {data, addr, write}, with        |
// |                  an optional empty-buffer bypass (MEM_REQ_BUFFER_BYPASS_EN) |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module mem_req_buffer #(
  parameter int BITS_DATA = 32,
  parameter int BITS_ADDR = 16,
  parameter int DEPTH     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic [BITS_DATA-1:0]    dataInput,
  input  logic [BITS_ADDR-1:0]    addrInput,
  input  logic                    writeInput,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [BITS_DATA-1:0]    dataOutput,
  output logic [BITS_ADDR-1:0]    dirrOutput,
  output logic                    writeOutput,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_ent_w = BITS_DATA + BITS_ADDR + 1;
  localparam logic [c_ptr_w:0] c_full = DEPTH[c_ptr_w:0];

  logic [c_ent_w-1:0] r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [c_ptr_w:0]   r_count;

  logic               w_empty;
  logic               w_bypass;
  logic               w_push;
  logic               w_pop;
  logic [c_ent_w-1:0] w_in_ent;
  logic [c_ent_w-1:0] w_head;

  assign w_empty  = (r_count == '0);
  assign w_in_ent = {dataInput, addrInput, writeInput};

`ifdef MEM_REQ_BUFFER_BYPASS_EN
  // Empty buffer: the incoming request is presented directly at the head.
  assign w_bypass = w_empty && inValid;
`else
  assign w_bypass = 1'b0;
`endif

  assign inReady  = (r_count != c_full);
  assign outValid = !w_empty || w_bypass;

  // A bypassed request taken by the consumer is never stored.
  assign w_push = inValid && inReady && !reset && !(w_bypass && outReady);
  assign w_pop  = !w_empty && outReady && !reset;

  assign w_head = w_bypass ? w_in_ent : (w_empty ? '0 : r_mem[r_head]);

  assign dataOutput  = w_head[c_ent_w-1 -: BITS_DATA];
  assign dirrOutput  = w_head[BITS_ADDR:1];
  assign writeOutput = w_head[0];
  assign count       = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= w_in_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_req_buffer : directed scoreboard bench for mem_req_buffer           |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
module tb_mem_req_buffer;

  localparam int c_depth = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [31:0] dataInput;
  logic [15:0] addrInput;
  logic        writeInput;
  logic        outValid;
  logic        outReady;
  logic [31:0] dataOutput;
  logic [15:0] dirrOutput;
  logic        writeOutput;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  logic [48:0] q[$];
  int          m_count = 0;

  mem_req_buffer #(.BITS_DATA(32), .BITS_ADDR(16), .DEPTH(c_depth)) dut (
    .clk(clk), .reset(reset),
    .inValid(inValid), .inReady(inReady),
    .dataInput(dataInput), .addrInput(addrInput), .writeInput(writeInput),
    .outValid(outValid), .outReady(outReady),
    .dataOutput(dataOutput), .dirrOutput(dirrOutput), .writeOutput(writeOutput),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check outputs against the model, clock, update model.
  task automatic step(input logic v, input logic [31:0] d, input logic [15:0] a,
                      input logic w, input logic r);
    logic        bp;
    logic        m_push;
    logic        m_pop;
    logic [48:0] exp_head;
    inValid = v; dataInput = d; addrInput = a; writeInput = w; outReady = r;
    #1;
`ifdef MEM_REQ_BUFFER_BYPASS_EN
    bp = (m_count == 0) && v;
`else
    bp = 1'b0;
`endif
    if (bp)               exp_head = {d, a, w};
    else if (m_count > 0) exp_head = q[0];
    else                  exp_head = '0;
    chk("count",    64'(count),    64'(m_count));
    chk("inReady",  64'(inReady),  64'(m_count != c_depth));
    chk("outValid", 64'(outValid), 64'((m_count != 0) || bp));
    chk("head",     64'({dataOutput, dirrOutput, writeOutput}), 64'(exp_head));
    m_push = v && (m_count != c_depth) && !(bp && r);
    m_pop  = r && (m_count != 0);
    @(posedge clk);
    #1;
    if (m_pop)  void'(q.pop_front());
    if (m_push) q.push_back({d, a, w});
    m_count = m_count + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && m_count > 0; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; inValid = 1'b0; dataInput = '0; addrInput = '0;
    writeInput = 1'b0; outReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state, then fill to full; the fifth push must bounce.
    step(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h1000 + i, 16'h0010 + 16'(i), i[0], 1'b0);
    step(1'b1, 32'h5555, 16'h0014, 1'b1, 1'b0);
    chk("full_count", 64'(count), 64'(4));
    chk("full_inReady", 64'(inReady), 64'(0));

    // Drain in order, then expect zeroed idle outputs.
    for (int i = 0; i < 4; i++) begin
      chk("drain_addr", 64'(dirrOutput), 64'(16'h0010 + 16'(i)));
      step(1'b0, '0, '0, 1'b0, 1'b1);
    end
    step(1'b0, '0, '0, 1'b0, 1'b0);

    // Streaming at count=2 wraps the pointers repeatedly.
    step(1'b1, 32'hA0000100, 16'h0100, 1'b0, 1'b0);
    step(1'b1, 32'hA0000101, 16'h0101, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'hA0000000 + i, 16'h0200 + 16'(i), i[1], 1'b1);
    chk("stream_count", 64'(count), 64'(2));
    drain();

    // Full with simultaneous pop: push ignored, count drops to 3.
    for (int i = 0; i < 4; i++) step(1'b1, 32'hB000 + i, 16'h0300 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 32'hBAD0, 16'h0099, 1'b1, 1'b1);
    chk("full_pop_count", 64'(count), 64'(3));
    drain();

    // Reset while pushing: the push is suppressed and everything is discarded.
    step(1'b1, 32'hC0000000, 16'h0400, 1'b0, 1'b0);
    step(1'b1, 32'hC0000001, 16'h0401, 1'b0, 1'b0);
    reset = 1'b1; inValid = 1'b1; dataInput = 32'hC0000002; addrInput = 16'h0402;
    @(posedge clk);
    #1;
    reset = 1'b0; inValid = 1'b0;
    q.delete(); m_count = 0;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_outValid", 64'(outValid), 64'(0));
    step(1'b0, '0, '0, 1'b0, 1'b0);

    // Head held for 5 cycles with a write entry.
    step(1'b1, 32'hD00D0001, 16'h0500, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_write", 64'(writeOutput), 64'(1));
      step(1'b0, '0, '0, 1'b0, 1'b0);
    end
    drain();

    // Empty buffer with push and pop together (pass-through when bypass is built in).
    step(1'b1, 32'hDEADBEEF, 16'h0600, 1'b1, 1'b1);
`ifdef MEM_REQ_BUFFER_BYPASS_EN
    chk("bypass_count", 64'(count), 64'(0));
`else
    chk("nobypass_count", 64'(count), 64'(1));
`endif
    drain();

    // Random traffic against the scoreboard.
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), $urandom, 16'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    drain();
    step(1'b0, '0, '0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
